// File: rtl/udp_frame_tx.sv
// rtl/udp_frame_tx.sv - Ethernet II / IPv4 / UDP frame transmitter with CRC-32 FCS
//
// Purpose:
//   Builds one complete Ethernet frame per accepted request: preamble + SFD,
//   a fixed 42-byte MAC/IP/UDP header (IP checksum computed on the fly),
//   payload fetched from an external synchronous RAM, zero padding up to the
//   46-byte Ethernet minimum, and the CRC-32 frame check sequence. Each frame
//   is followed by an inter-frame gap before the block is ready again.
//
// Ports:
//   clk          byte clock, all logic on the rising edge
//   clr          synchronous active-high reset
//   start        frame request, only looked at while idle
//   payload_len  UDP payload length in bytes (1..1472)
//   abort        terminate the frame currently on the wire
//   rd_addr      payload RAM word address
//   rd_data      payload RAM word, valid one cycle after rd_addr
//   txd          transmit byte
//   tx_en        transmit byte valid
//   tx_er        transmit error (abort cycle only)
//   busy         frame in progress
//   done         one-cycle pulse at the end of the inter-frame gap
//   len_err      one-cycle pulse when a request with an illegal length is rejected

module udp_frame_tx #(
    parameter logic [47:0] DST_MAC   = 48'h28D244DC6EFE,
    parameter logic [47:0] SRC_MAC   = 48'h000A3501FEC0,
    parameter logic [31:0] SRC_IP    = 32'hC0A80002,
    parameter logic [31:0] DST_IP    = 32'hC0A80003,
    parameter logic [15:0] SRC_PORT  = 16'h8000,
    parameter logic [15:0] DST_PORT  = 16'h8000,
    parameter logic [7:0]  TTL       = 8'h80,
    parameter int          WORD_W    = 32,
    parameter int          ADDR_W    = 9,
    parameter int          IFG_BYTES = 12
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [15:0]       payload_len,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WORD_W-1:0] rd_data,
    output logic [7:0]        txd,
    output logic              tx_en,
    output logic              tx_er,
    output logic              busy,
    output logic              done,
    output logic              len_err
);

    localparam int          BPW       = WORD_W / 8;
    localparam int          LB        = $clog2(BPW);
    localparam logic [15:0] LANE_MASK = 16'(BPW - 1);
    localparam logic [15:0] MAX_LEN   = 16'd1472;
    localparam logic [15:0] MIN_PAY   = 16'd18;
    localparam logic [15:0] IFG_LAST  = 16'(IFG_BYTES);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CSUM     = 3'd1,
        PREAMBLE = 3'd2,
        HEADER   = 3'd3,
        PAYLOAD  = 3'd4,
        PAD      = 3'd5,
        FCS      = 3'd6,
        IFG      = 3'd7
    } state_t;

    state_t            state;
    logic [15:0]       cnt;
    logic [15:0]       len;
    logic [15:0]       ident;
    logic [31:0]       sum;
    logic [335:0]      hdr_sh;
    logic [WORD_W-1:0] sh;
    logic [31:0]       crc;

    logic [15:0]       total_len;
    logic [15:0]       udp_len;
    logic [15:0]       last_idx;
    logic [15:0]       csum_val;
    logic [31:0]       hdr_sum;
    logic [15:0]       ptr;
    logic [ADDR_W-1:0] ptr_addr;
    logic              lane0;
    logic [7:0]        byte_out;
    logic [31:0]       crc_next;

    // Reflected CRC-32, one byte per call, LSB of the byte first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    always_comb begin
        total_len = len + 16'd28;
        udp_len   = len + 16'd8;
        last_idx  = len - 16'd1;
        // Second fold: sum already holds the first fold, so this cannot carry.
        csum_val  = ~(sum[15:0] + sum[31:16]);
        // Ten header words with the checksum field taken as zero.
        hdr_sum   = 32'h4500 + {16'h0, total_len} + {16'h0, ident} + 32'h4000
                  + {16'h0, TTL, 8'h11}
                  + {16'h0, SRC_IP[31:16]} + {16'h0, SRC_IP[15:0]}
                  + {16'h0, DST_IP[31:16]} + {16'h0, DST_IP[15:0]};
        lane0     = (cnt & LANE_MASK) == 16'd0;

        // The RAM is synchronous, so the address issued at the edge that emits
        // byte k must be the word holding byte k+2. Clamped to the last payload
        // byte so rd_addr rests on the final word at the end of the frame.
        if (state == HEADER) begin
            ptr = (cnt == 16'd41 && len > 16'd1) ? 16'd1 : 16'd0;
        end else begin
            ptr = ((cnt + 16'd2) > last_idx) ? last_idx : (cnt + 16'd2);
        end
        ptr_addr = ADDR_W'(ptr >> LB);

        byte_out = 8'h00;
        case (state)
            PREAMBLE: byte_out = (cnt == 16'd7) ? 8'hD5 : 8'h55;
            HEADER:   byte_out = hdr_sh[335:328];
            PAYLOAD:  byte_out = lane0 ? rd_data[WORD_W-1 -: 8] : sh[WORD_W-1 -: 8];
            FCS:      byte_out = ~crc[7:0];
            default:  byte_out = 8'h00;
        endcase
        crc_next = crc_byte(crc, byte_out);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            txd     <= 8'h00;
            tx_en   <= 1'b0;
            tx_er   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            len_err <= 1'b0;
            rd_addr <= '0;
            ident   <= 16'h0000;
            cnt     <= 16'h0000;
            len     <= 16'h0000;
            sum     <= 32'h0;
            hdr_sh  <= '0;
            sh      <= '0;
            crc     <= 32'hFFFFFFFF;
        end else begin
            done    <= 1'b0;
            len_err <= 1'b0;
            tx_er   <= 1'b0;
            case (state)
                IDLE: begin
                    txd   <= 8'h00;
                    tx_en <= 1'b0;
                    if (start) begin
                        if (payload_len != 16'd0 && payload_len <= MAX_LEN) begin
                            len     <= payload_len;
                            busy    <= 1'b1;
                            rd_addr <= '0;
                            cnt     <= 16'd0;
                            state   <= CSUM;
                        end else begin
                            len_err <= 1'b1;
                        end
                    end
                end

                CSUM: begin
                    txd   <= 8'h00;
                    tx_en <= 1'b0;
                    if (cnt == 16'd0) begin
                        sum <= hdr_sum;
                        cnt <= 16'd1;
                    end else if (cnt == 16'd1) begin
                        sum <= {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
                        cnt <= 16'd2;
                    end else begin
                        hdr_sh <= {DST_MAC, SRC_MAC, 16'h0800,
                                   8'h45, 8'h00, total_len, ident, 16'h4000,
                                   TTL, 8'h11, csum_val, SRC_IP, DST_IP,
                                   SRC_PORT, DST_PORT, udp_len, 16'h0000};
                        crc    <= 32'hFFFFFFFF;
                        cnt    <= 16'd0;
                        state  <= PREAMBLE;
                    end
                end

                PREAMBLE, HEADER, PAYLOAD, PAD, FCS: begin
                    tx_en <= 1'b1;
                    txd   <= byte_out;
                    if (abort) begin
                        tx_er <= 1'b1;
                        ident <= ident + 16'd1;
                        cnt   <= 16'd0;
                        state <= IFG;
                    end else begin
                        case (state)
                            PREAMBLE: begin
                                if (cnt == 16'd7) begin
                                    cnt   <= 16'd0;
                                    state <= HEADER;
                                end else begin
                                    cnt <= cnt + 16'd1;
                                end
                            end
                            HEADER: begin
                                crc    <= crc_next;
                                hdr_sh <= hdr_sh << 8;
                                if (cnt >= 16'd40) begin
                                    rd_addr <= ptr_addr;
                                end
                                if (cnt == 16'd41) begin
                                    cnt   <= 16'd0;
                                    state <= PAYLOAD;
                                end else begin
                                    cnt <= cnt + 16'd1;
                                end
                            end
                            PAYLOAD: begin
                                crc     <= crc_next;
                                rd_addr <= ptr_addr;
                                // Lane 0 consumes the fresh RAM word; the rest
                                // of that word is drained from sh.
                                sh      <= lane0 ? (rd_data << 8) : (sh << 8);
                                if (cnt == last_idx) begin
                                    cnt   <= 16'd0;
                                    state <= (len < MIN_PAY) ? PAD : FCS;
                                end else begin
                                    cnt <= cnt + 16'd1;
                                end
                            end
                            PAD: begin
                                crc <= crc_next;
                                if (cnt == (MIN_PAY - 16'd1 - len)) begin
                                    cnt   <= 16'd0;
                                    state <= FCS;
                                end else begin
                                    cnt <= cnt + 16'd1;
                                end
                            end
                            default: begin
                                // FCS: shift the finished CRC out LSB first.
                                crc <= {8'h00, crc[31:8]};
                                if (cnt == 16'd3) begin
                                    ident <= ident + 16'd1;
                                    cnt   <= 16'd0;
                                    state <= IFG;
                                end else begin
                                    cnt <= cnt + 16'd1;
                                end
                            end
                        endcase
                    end
                end

                IFG: begin
                    txd   <= 8'h00;
                    tx_en <= 1'b0;
                    if (cnt == IFG_LAST) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        cnt   <= 16'd0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                default: begin
                    txd   <= 8'h00;
                    tx_en <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udp_frame_tx.sv
// tb/tb_udp_frame_tx.sv - directed vector bench for udp_frame_tx at 8/32/64-bit RAM widths

module tb_udp_frame_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr;
    logic        start;
    logic        abort;
    logic [15:0] payload_len;

    logic [8:0]  a32;  logic [31:0] d32; logic [7:0] txd32;
    logic en32, er32, busy32, done32, lerr32;
    logic [10:0] a8;   logic [7:0]  d8;  logic [7:0] txd8;
    logic en8, er8, busy8, done8, lerr8;
    logic [7:0]  a64;  logic [63:0] d64; logic [7:0] txd64;
    logic en64, er64, busy64, done64, lerr64;

    udp_frame_tx u32 (
        .clk(clk), .clr(clr), .start(start), .payload_len(payload_len), .abort(abort),
        .rd_addr(a32), .rd_data(d32), .txd(txd32), .tx_en(en32), .tx_er(er32),
        .busy(busy32), .done(done32), .len_err(lerr32)
    );

    udp_frame_tx #(.WORD_W(8), .ADDR_W(11)) u8 (
        .clk(clk), .clr(clr), .start(start), .payload_len(payload_len), .abort(abort),
        .rd_addr(a8), .rd_data(d8), .txd(txd8), .tx_en(en8), .tx_er(er8),
        .busy(busy8), .done(done8), .len_err(lerr8)
    );

    udp_frame_tx #(.WORD_W(64), .ADDR_W(8)) u64 (
        .clk(clk), .clr(clr), .start(start), .payload_len(payload_len), .abort(abort),
        .rd_addr(a64), .rd_data(d64), .txd(txd64), .tx_en(en64), .tx_er(er64),
        .busy(busy64), .done(done64), .len_err(lerr64)
    );

    // Byte-ramp RAM, big-endian within a word, one-cycle read latency.
    function automatic logic [63:0] ram_word(input int addr, input int bpw);
        logic [63:0] w;
        w = 64'h0;
        for (int j = 0; j < bpw; j++) w = {w[55:0], 8'(addr * bpw + j)};
        return w;
    endfunction

    always @(posedge clk) begin
        d8  <= 8'(ram_word(int'(a8), 1));
        d32 <= 32'(ram_word(int'(a32), 4));
        d64 <= ram_word(int'(a64), 8);
    end

    logic [7:0] txd_v [3];
    logic       en_v  [3];
    logic       er_v  [3];
    assign txd_v[0] = txd32; assign en_v[0] = en32; assign er_v[0] = er32;
    assign txd_v[1] = txd8;  assign en_v[1] = en8;  assign er_v[1] = er8;
    assign txd_v[2] = txd64; assign en_v[2] = en64; assign er_v[2] = er64;

    logic [7:0] cap [3][2048];
    int         ncap [3];
    int         nrun [3];
    int         ner  [3];
    logic       prev_en [3];
    int         low_run;
    int         done_gap;
    logic [7:0] exp_b [2048];
    int         exp_n;
    int         nchk = 0;
    int         nfail = 0;

    typedef struct {
        int          len;
        bit          ok;
        int          cycles;
        logic [15:0] id;
        logic [15:0] udp_len;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every cycle of the test passes through here: sample at the falling edge.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (en_v[i]) begin
                if (ncap[i] < 2048) cap[i][ncap[i]] = txd_v[i];
                ncap[i]++;
                if (!prev_en[i]) nrun[i]++;
            end
            if (er_v[i]) ner[i]++;
            prev_en[i] = en_v[i];
        end
        if (done32) done_gap = low_run;
        low_run = en32 ? 0 : low_run + 1;
    endtask

    task automatic clear_cap();
        for (int i = 0; i < 3; i++) begin
            ncap[i] = 0; nrun[i] = 0; ner[i] = 0; prev_en[i] = en_v[i];
        end
        done_gap = -1;
    endtask

    task automatic push(input logic [63:0] v, input int n);
        for (int k = n - 1; k >= 0; k--) begin
            exp_b[exp_n] = v[8*k +: 8];
            exp_n++;
        end
    endtask

    function automatic logic [15:0] tb_csum(input int len, input logic [15:0] id);
        logic [31:0] s;
        s = 32'h4500 + 32'(28 + len) + {16'h0, id} + 32'h4000 + 32'h8011
          + 32'hC0A8 + 32'h0002 + 32'hC0A8 + 32'h0003;
        while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        return ~s[15:0];
    endfunction

    task automatic build_exp(input int len, input logic [15:0] id);
        logic [31:0] c;
        logic [7:0]  b;
        exp_n = 0;
        for (int i = 0; i < 7; i++) push(64'h55, 1);
        push(64'hD5, 1);
        push(64'h28D244DC6EFE, 6);
        push(64'h000A3501FEC0, 6);
        push(64'h0800, 2);
        push(64'h4500, 2);
        push(64'(28 + len), 2);
        push({48'h0, id}, 2);
        push(64'h4000, 2);
        push(64'h8011, 2);
        push({48'h0, tb_csum(len, id)}, 2);
        push(64'hC0A80002, 4);
        push(64'hC0A80003, 4);
        push(64'h80008000, 4);
        push(64'(8 + len), 2);
        push(64'h0000, 2);
        for (int i = 0; i < len; i++) push(64'(i & 255), 1);
        for (int i = len; i < 18; i++) push(64'h00, 1);
        c = 32'hFFFFFFFF;
        for (int j = 8; j < exp_n; j++) begin
            b = exp_b[j];
            for (int i = 0; i < 8; i++) begin
                if (c[0] ^ b[i]) c = (c >> 1) ^ 32'hEDB88320;
                else             c = c >> 1;
            end
        end
        c = ~c;
        for (int k = 0; k < 4; k++) begin
            exp_b[exp_n] = c[8*k +: 8];
            exp_n++;
        end
    endtask

    function automatic logic [15:0] field16(input int i, input int off);
        return {cap[i][off], cap[i][off+1]};
    endfunction

    task automatic start_frame(input string name, input int len);
        int lat;
        clear_cap();
        payload_len = 16'(len);
        start = 1'b1;
        step();
        start = 1'b0;
        check({name, "_busy"}, {63'h0, busy32}, 64'h1);
        lat = 0;
        while (!en32 && lat < 20) begin
            step();
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'd4);
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (!done32 && t < 3000) begin
            step();
            t++;
        end
        check({name, "_done_busy"}, {62'h0, busy32, done32}, 64'h1);
        check({name, "_ifg"}, 64'(done_gap), 64'd12);
        step();
        check({name, "_done_pulse"}, {63'h0, done32}, 64'h0);
    endtask

    task automatic compare_stream(input string name, input int upto);
        int bad;
        for (int i = 0; i < 3; i++) begin
            bad = -1;
            for (int j = 0; j < upto; j++) begin
                if (bad < 0 && cap[i][j] !== exp_b[j]) bad = j;
            end
            if (bad >= 0) begin
                nfail++;
                $display("FAIL %s_stream dut%0d: byte %0d got %0h expected %0h",
                         name, i, bad, cap[i][bad], exp_b[bad]);
            end
            nchk++;
        end
    endtask

    task automatic run_frame(input string name, input int len, input logic [15:0] id);
        start_frame(name, len);
        wait_done(name);
        build_exp(len, id);
        for (int i = 0; i < 3; i++) check({name, "_count"}, 64'(ncap[i]), 64'(exp_n));
        compare_stream(name, exp_n);
        check({name, "_runs_er"}, {32'(nrun[0]), 32'(ner[0])}, {32'd1, 32'd0});
        check({name, "_ident"}, {48'h0, field16(0, 26)}, {48'h0, id});
    endtask

    task automatic reject(input string name, input int len);
        clear_cap();
        payload_len = 16'(len);
        start = 1'b1;
        step();
        start = 1'b0;
        check({name, "_len_err"}, {62'h0, lerr32, busy32}, 64'h2);
        step();
        check({name, "_len_err_pulse"}, {61'h0, lerr32, lerr8, lerr64}, 64'h0);
        repeat (6) step();
        check({name, "_quiet"}, {32'(ncap[0] + ncap[1] + ncap[2]), 29'h0, busy32, busy8, busy64}, 64'h0);
    endtask

    initial begin
        int t;
        clr = 1'b1; start = 1'b0; abort = 1'b0; payload_len = 16'd0;
        low_run = 0; done_gap = -1;
        for (int i = 0; i < 3; i++) begin
            ncap[i] = 0; nrun[i] = 0; ner[i] = 0; prev_en[i] = 1'b0;
        end
        repeat (3) step();
        clr = 1'b0;
        step();
        check("reset_u32", {txd32, en32, er32, busy32, done32, lerr32, a32}, 64'h0);
        check("reset_u8_u64", {txd8, en8, er8, busy8, done8, lerr8, a8,
                               txd64, en64, er64, busy64, done64, lerr64, a64}, 64'h0);

        // Abort at payload byte 5 (55 bytes already out), then abort held in IFG.
        start_frame("abort", 18);
        t = 0;
        while (ncap[0] < 55 && t < 200) begin
            step();
            t++;
        end
        check("abort_reach", 64'(ncap[0]), 64'd55);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_er_en", {62'h0, er32, en32}, 64'h3);
        step();
        abort = 1'b1;
        repeat (3) step();
        abort = 1'b0;
        wait_done("abort");
        check("abort_totals", {16'(ncap[0]), 16'(ner[0]), 16'(nrun[0]), 16'(ner[1] + ner[2])},
              {16'd56, 16'd1, 16'd1, 16'd2});
        build_exp(18, 16'd0);
        compare_stream("abort_prefix", 55);

        run_frame("after_abort", 18, 16'd1);

        // Reset in the middle of the header.
        start_frame("clr", 18);
        t = 0;
        while (ncap[0] < 28 && t < 200) begin
            step();
            t++;
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_u32", {txd32, en32, er32, busy32, done32, lerr32, a32}, 64'h0);
        check("clr_u8_u64", {txd8, en8, er8, busy8, done8, lerr8, a8,
                             txd64, en64, er64, busy64, done64, lerr64, a64}, 64'h0);
        repeat (3) step();
        run_frame("post_clr", 18, 16'd0);
        check("post_clr_csum", {48'h0, field16(0, 32)}, 64'h7969);
        check("post_clr_total_len", {48'h0, field16(0, 24)}, 64'h002E);

        tbl[0] = '{len: 18,   ok: 1'b1, cycles: 72,   id: 16'd1, udp_len: 16'h001A};
        tbl[1] = '{len: 1,    ok: 1'b1, cycles: 72,   id: 16'd2, udp_len: 16'h0009};
        tbl[2] = '{len: 1473, ok: 1'b0, cycles: 0,    id: 16'd0, udp_len: 16'h0000};
        tbl[3] = '{len: 0,    ok: 1'b0, cycles: 0,    id: 16'd0, udp_len: 16'h0000};
        tbl[4] = '{len: 17,   ok: 1'b1, cycles: 72,   id: 16'd3, udp_len: 16'h0019};
        tbl[5] = '{len: 19,   ok: 1'b1, cycles: 73,   id: 16'd4, udp_len: 16'h001B};
        tbl[6] = '{len: 1472, ok: 1'b1, cycles: 1526, id: 16'd5, udp_len: 16'h05C8};
        tbl[7] = '{len: 4,    ok: 1'b1, cycles: 72,   id: 16'd6, udp_len: 16'h000C};

        for (int v = 0; v < 8; v++) begin
            string nm;
            nm = $sformatf("vec%0d_len%0d", v, tbl[v].len);
            if (tbl[v].ok) begin
                run_frame(nm, tbl[v].len, tbl[v].id);
                check({nm, "_cycles"}, 64'(ncap[0]), 64'(tbl[v].cycles));
                check({nm, "_udp_len"}, {48'h0, field16(0, 46)}, {48'h0, tbl[v].udp_len});
                if (tbl[v].len == 1472) begin
                    check({nm, "_rd_addr"}, {21'h0, a8, 24'h0, a64},
                          {21'h0, 11'd1471, 24'h0, 8'd183});
                end
            end else begin
                reject(nm, tbl[v].len);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/udp_frame_tx.md
UDP_FRAME_TX -- requirements
Module: udp_frame_tx

Interface
REQ-001 SHALL have parameter DST_MAC, 48'h28D244DC6EFE, destination MAC.
REQ-002 SHALL have parameter SRC_MAC, 48'h000A3501FEC0, source MAC.
REQ-003 SHALL have parameters SRC_IP 32'hC0A80002, DST_IP 32'hC0A80003, SRC_PORT 16'h8000, DST_PORT 16'h8000, TTL 8'h80.
REQ-004 SHALL have parameter WORD_W, 32, payload RAM word width; legal values are 8, 16, 32 and 64.
REQ-005 SHALL have parameter ADDR_W, 9, payload RAM address width; parameter IFG_BYTES, 12, inter-frame gap in cycles.
REQ-006 clk  in  1  byte clock; all logic on rising edge.
REQ-007 clr  in  1  reset, synchronous, active-high.
REQ-008 start  in  1  frame request, sampled in IDLE only.
REQ-009 payload_len  in  16  UDP payload bytes, legal range 1..1472.
REQ-010 abort  in  1  terminate current frame.
REQ-011 rd_addr  out  ADDR_W  payload RAM word address; rd_data  in  WORD_W  RAM data, 1-cycle read latency.
REQ-012 txd  out  8  transmit byte; tx_en  out  1  byte valid; tx_er  out  1  transmit error.
REQ-013 busy  out  1  frame in progress; done  out  1  end-of-frame pulse; len_err  out  1  rejected-request pulse.

Function
REQ-014 States SHALL be IDLE, CSUM, PREAMBLE, HEADER, PAYLOAD, PAD, FCS, IFG; any other encoding SHALL go to IDLE on the next edge.
REQ-015 In IDLE, start=1 with a legal payload_len SHALL latch the length, set busy, and enter CSUM; start is ignored in every other state.
REQ-016 In IDLE, start=1 with payload_len of 0 or above 1472 SHALL pulse len_err for 1 cycle; the block stays in IDLE and busy stays 0.
REQ-017 CSUM SHALL last exactly 3 cycles, computing the IP header checksum:
- one's-complement sum of the ten header words, checksum field 0
- fold carries twice, then invert.
REQ-018 tx_en SHALL rise exactly 4 cycles after the accepting edge.
REQ-019 PREAMBLE SHALL output 7 bytes of 0x55, then 1 byte of 0xD5.
REQ-020 HEADER SHALL output 42 bytes, MSB-first per field:
- DST_MAC, SRC_MAC, 0x0800
- IP: 0x45, 0x00, total_len=28+len, ident, 0x4000, TTL, 0x11, checksum, SRC_IP, DST_IP
- UDP: SRC_PORT, DST_PORT, udp_len=8+len, 0x0000.
REQ-021 ident SHALL be 0 after reset and increment by 1 after each completed or aborted frame, wrapping 0xFFFF->0.
REQ-022 PAYLOAD SHALL output exactly len bytes:
- rd_addr starts at 0 and is presented one cycle before its data is needed
- bytes go out big-endian, first byte = rd_data[WORD_W-1:WORD_W-8]
- unused bytes of the final word are discarded.
REQ-023 PAD SHALL output max(0, 18-len) bytes of 0x00, so the Ethernet payload is at least 46 bytes.
REQ-024 CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF) SHALL cover DST_MAC through the last pad byte.
REQ-025 FCS SHALL output the inverted CRC over 4 bytes, least-significant byte first.
REQ-026 IFG SHALL hold tx_en=0 and txd=0x00 for IFG_BYTES cycles, then pulse done for 1 cycle, clear busy, and return to IDLE.
REQ-027 abort=1 in PREAMBLE through FCS SHALL drive tx_er=1 with tx_en=1 for that one cycle, then enter IFG; abort in IDLE, CSUM or IFG is ignored.
REQ-028 tx_er SHALL be 0 at all other times.
REQ-029 Except for the abort cycle, tx_en SHALL be high for exactly 8+42+max(len,18)+4 consecutive cycles.

Reset
REQ-030 clr=1 SHALL, on the next edge and regardless of state, force:
- state IDLE
- txd=0, tx_en=0, tx_er=0
- busy=0, done=0, len_err=0
- rd_addr=0, ident=0.
REQ-031 A clr mid-frame SHALL truncate the frame without emitting FCS; the first frame after reset uses ident 0.

Verification
REQ-032 len=18, default parameters, rd_data byte-ramp 0x00.. -> expected response:
- 72 tx_en cycles, IP total_len 0x002E, ident 0
- IP checksum 0x7969
- FCS matches software CRC-32 of bytes 8..67.
REQ-033 len=1 -> 72 tx_en cycles, udp_len 0x0009, 17 zero pad bytes, correct FCS.
REQ-034 len=1472 with WORD_W=8 and WORD_W=64 -> 1526 tx_en cycles, identical txd stream, rd_addr final value 1471 and 183 respectively.
REQ-035 len=1473 -> len_err high for 1 cycle, busy and tx_en stay 0; len=0 gives the same response.
REQ-036 abort at payload byte 5, then a second start -> tx_er=1 for 1 cycle, tx_en low for 12 cycles, done pulse; second frame ident=1.
REQ-037 clr in the middle of HEADER, then start with len=18 -> all outputs 0 on the next edge; new frame carries ident 0 and checksum 0x7969.
